seg_scan_display: RTL
=====================

SEG_SCAN_DISPLAY -- requirements
Module: seg_scan_display

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed digits; legal 1..8.
REQ-002 Parameter TICK_DIV, default 3, clk cycles per scan tick; legal 1..65535.
REQ-003 Parameter DWELL_TICKS, default 4, scan ticks per digit slot; legal 2..255.
REQ-004 Parameter BLANK_TICKS, default 1, leading ticks of each slot with all anodes off; legal 0..DWELL_TICKS-1.
REQ-005 clk  input  1  sole clock, rising-edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 data  input  4*NUM_DIGITS  hex nibbles; nibble i (data[4i+3:4i]) drives digit i, digit 0 least significant.
REQ-008 dp_mask  input  NUM_DIGITS  bit i = 1 lights decimal point of digit i.
REQ-009 lzs_en  input  1  leading-zero suppression request (effective only per REQ-030).
REQ-010 anode  output  NUM_DIGITS  active-low digit enables; anode[i] drives digit i.
REQ-011 catode  output  7  active-high segments, bit order {g,f,e,d,c,b,a}.
REQ-012 dp  output  1  active-high decimal point segment.
REQ-013 frame_done  output  1  one-clk pulse at end of each full scan.

Function
REQ-014 Single clock domain; no derived clocks; all outputs registered.
REQ-015 Prescaler counts 0..TICK_DIV-1, wraps; tick asserted for the one clk where count = TICK_DIV-1.
REQ-016 Slot counter counts ticks 0..DWELL_TICKS-1 within a slot; advances only on tick.
REQ-017 Phase FSM: BLANK while slot count < BLANK_TICKS, SHOW otherwise; BLANK skipped entirely when BLANK_TICKS = 0.
REQ-018 Digit index scans NUM_DIGITS-1 down to 0 (MSD first), advancing on the tick where slot count = DWELL_TICKS-1; after 0 wraps to NUM_DIGITS-1.
REQ-019 Slot length = DWELL_TICKS*TICK_DIV clk; frame length = NUM_DIGITS*DWELL_TICKS*TICK_DIV clk, exactly.
REQ-020 In BLANK: anode all ones, catode 0, dp 0.
REQ-021 In SHOW for digit k: anode[k] = 0, all other anode bits 1; catode = decode(shadow nibble k); dp = shadow dp_mask[k].
REQ-022 Decode 0-F: 0111111, 0000110, 1011011, 1001111, 1100110, 1101101, 1111101, 0000111, 1111111, 1100111, 1110111, 1111100, 0111001, 1011110, 1111001, 1110001.
REQ-023 Shadow registers hold data and dp_mask; reloaded from inputs in the clk where digit index wraps 0 -> NUM_DIGITS-1; no mid-frame tearing.
REQ-024 frame_done asserted in that same reload clk, for exactly one clk.
REQ-025 Input changes between reloads have no effect on outputs.
REQ-026 At most one anode bit low in any clk; never low during BLANK.
REQ-027 NUM_DIGITS = 1: index stays 0, reload and frame_done every slot.
REQ-028 Output transitions occur only on the clk edge of a phase or index change.

Reset
REQ-029 reset low asynchronously forces: anode all ones, catode 0, dp 0, frame_done 0, prescaler 0, slot count 0, index NUM_DIGITS-1, phase BLANK (SHOW if BLANK_TICKS = 0), shadow data 0, shadow dp_mask 0; scan restarts from digit NUM_DIGITS-1 on release; reset mid-frame discards the frame with no frame_done.

Configuration
REQ-030 Macro SEG_SCAN_LZS_EN defined: when lzs_en = 1, digit k (k > 0) whose shadow nibbles k..NUM_DIGITS-1 are all zero is blank-in-SHOW (anode all ones, catode 0, dp 0) while slot timing unchanged; digit 0 never suppressed.
REQ-031 Macro SEG_SCAN_LZS_EN undefined: suppression logic absent, lzs_en ignored, all digits always shown.

Verification
REQ-032 Defaults, data=16'h1A2F after reset release -> first frame all digits show 0111111; second frame digit3 0000110, digit2 1110111, digit1 1011011, digit0 1110001, each slot 12 clk with first 3 clk blanked.
REQ-033 TICK_DIV=1, DWELL_TICKS=2, BLANK_TICKS=0, NUM_DIGITS=4 -> frame_done pulses every 8 clk exactly, anode sequence 0111,1011,1101,1110.
REQ-034 data changed 16'h1234 -> 16'h5678 mid-frame -> remaining slots still show 2,3,4 nibbles; 5678 appears only after next frame_done.
REQ-035 SEG_SCAN_LZS_EN defined, lzs_en=1, data=16'h0040 -> digits 3,2 all anodes high; digit1 1100110; digit0 0111111; data=16'h0000 -> only digit0 lit.
REQ-036 reset pulsed low mid-slot of digit 1 -> same clk outputs anode=1111, catode=0, no frame_done; after release scan restarts at digit 3 with shadow 0.
REQ-037 dp_mask=4'b0100 -> dp=1 only during SHOW of digit 2, 0 in all BLANK phases.

Source files
------------

// File: rtl/seg_scan_display.sv
`default_nettype none
// seg_scan_display: multiplexed 7-segment scanner with leading blanking and a shadow register reloaded per frame.
// Leading-zero suppression is compiled in by defining SEG_SCAN_LZS_EN. Rev 1.0
module seg_scan_display #(
  parameter int NUM_DIGITS  = 4,
  parameter int TICK_DIV    = 3,
  parameter int DWELL_TICKS = 4,
  parameter int BLANK_TICKS = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic                    lzs_en,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [6:0]              catode,
  output logic                    dp,
  output logic                    frame_done
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = 8;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SLOT_MAX  = SW'(DWELL_TICKS - 1);
  localparam logic [SW-1:0] BLANK_END = SW'(BLANK_TICKS);
  localparam logic [IW-1:0] IDX_TOP   = IW'(NUM_DIGITS - 1);

  typedef enum logic {BLANK = 1'b0, SHOW = 1'b1} phase_t;
  localparam phase_t PHASE_RST = (BLANK_TICKS == 0) ? SHOW : BLANK;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'h0:    seg_decode = 7'b0111111;
      4'h1:    seg_decode = 7'b0000110;
      4'h2:    seg_decode = 7'b1011011;
      4'h3:    seg_decode = 7'b1001111;
      4'h4:    seg_decode = 7'b1100110;
      4'h5:    seg_decode = 7'b1101101;
      4'h6:    seg_decode = 7'b1111101;
      4'h7:    seg_decode = 7'b0000111;
      4'h8:    seg_decode = 7'b1111111;
      4'h9:    seg_decode = 7'b1100111;
      4'hA:    seg_decode = 7'b1110111;
      4'hB:    seg_decode = 7'b1111100;
      4'hC:    seg_decode = 7'b0111001;
      4'hD:    seg_decode = 7'b1011110;
      4'hE:    seg_decode = 7'b1111001;
      default: seg_decode = 7'b1110001;
    endcase
  endfunction

  logic [PW-1:0]           presc, presc_nxt;
  logic [SW-1:0]           slot, slot_nxt;
  logic [IW-1:0]           idx, idx_nxt;
  phase_t                  phase, phase_nxt;
  logic [4*NUM_DIGITS-1:0] data_sh, data_sh_nxt;
  logic [NUM_DIGITS-1:0]   dpm_sh, dpm_sh_nxt;
  logic [NUM_DIGITS-1:0]   anode_nxt, sel;
  logic [6:0]              catode_nxt;
  logic                    dp_nxt, tick, wrap, dp_bit, suppress;
  logic [3:0]              nib;

`ifdef SEG_SCAN_LZS_EN
  logic zero_run;
`else
  logic unused_lzs;
  assign unused_lzs = lzs_en;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc      <= '0;
      slot       <= '0;
      idx        <= IDX_TOP;
      phase      <= PHASE_RST;
      data_sh    <= '0;
      dpm_sh     <= '0;
      anode      <= '1;
      catode     <= '0;
      dp         <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      presc      <= presc_nxt;
      slot       <= slot_nxt;
      idx        <= idx_nxt;
      phase      <= phase_nxt;
      data_sh    <= data_sh_nxt;
      dpm_sh     <= dpm_sh_nxt;
      anode      <= anode_nxt;
      catode     <= catode_nxt;
      dp         <= dp_nxt;
      frame_done <= wrap;
    end
  end

  always_comb begin
    tick      = (presc == PRESC_MAX);
    presc_nxt = tick ? '0 : presc + 1'b1;
    slot_nxt  = slot;
    idx_nxt   = idx;
    wrap      = 1'b0;
    if (tick) begin
      if (slot == SLOT_MAX) begin
        slot_nxt = '0;
        if (idx == '0) begin
          idx_nxt = IDX_TOP;
          wrap    = 1'b1;
        end else begin
          idx_nxt = idx - 1'b1;
        end
      end else begin
        slot_nxt = slot + 1'b1;
      end
    end

    phase_nxt = phase;
    case (phase)
      BLANK: if (slot_nxt >= BLANK_END) phase_nxt = SHOW;
      SHOW:  if ((BLANK_TICKS != 0) && (slot_nxt < BLANK_END)) phase_nxt = BLANK;
    endcase

    data_sh_nxt = wrap ? data : data_sh;
    dpm_sh_nxt  = wrap ? dp_mask : dpm_sh;

    // Outputs follow next-state so they change on the same edge as phase/index.
    sel      = '0;
    nib      = 4'h0;
    dp_bit   = 1'b0;
    suppress = 1'b0;
`ifdef SEG_SCAN_LZS_EN
    zero_run = 1'b1;
`endif
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
`ifdef SEG_SCAN_LZS_EN
      zero_run = zero_run && (data_sh_nxt[4*i +: 4] == 4'h0);
`endif
      if (idx_nxt == IW'(i)) begin
        sel[i] = 1'b1;
        nib    = data_sh_nxt[4*i +: 4];
        dp_bit = dpm_sh_nxt[i];
`ifdef SEG_SCAN_LZS_EN
        suppress = lzs_en && zero_run && (i > 0);
`endif
      end
    end

    anode_nxt  = '1;
    catode_nxt = '0;
    dp_nxt     = 1'b0;
    if ((phase_nxt == SHOW) && !suppress) begin
      anode_nxt  = ~sel;
      catode_nxt = seg_decode(nib);
      dp_nxt     = dp_bit;
    end
  end

endmodule
`default_nettype wire
